// File: rtl/fpga_runner_pkg.sv
// Shared opcode/state encodings and instruction field layout for the FPGA program runner.
// Instruction word: {opcode[3:0], target[W-1:0], a_imm, a[W-1:0], b_imm, b[W-1:0]}.
package fpga_runner_pkg;

  localparam int unsigned OPCODE_W = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MOV  = 4'd3,
    OP_OUT  = 4'd4,
    OP_JEQ  = 4'd5,
    OP_JLT  = 4'd6,
    OP_HALT = 4'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_EXEC  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int unsigned instr_width(input int unsigned w);
    return 3 * w + 6;
  endfunction

  function automatic int unsigned off_b(input int unsigned w);
    return 0 * w;
  endfunction

  function automatic int unsigned off_b_imm(input int unsigned w);
    return w;
  endfunction

  function automatic int unsigned off_a(input int unsigned w);
    return w + 1;
  endfunction

  function automatic int unsigned off_a_imm(input int unsigned w);
    return 2 * w + 1;
  endfunction

  function automatic int unsigned off_target(input int unsigned w);
    return 2 * w + 2;
  endfunction

  function automatic int unsigned off_opcode(input int unsigned w);
    return 3 * w + 2;
  endfunction

endpackage

// File: rtl/fpga_runner_alu.sv
// Operand select (immediate or local memory) plus the data-path ops and branch compares.
module fpga_runner_alu #(
  parameter int unsigned W = 12
) (
  input  logic [3:0]   op,
  input  logic         a_imm,
  input  logic [W-1:0] a_field,
  input  logic [W-1:0] a_mem,
  input  logic         b_imm,
  input  logic [W-1:0] b_field,
  input  logic [W-1:0] b_mem,
  output logic [W-1:0] a_val,
  output logic [W-1:0] b_val,
  output logic [W-1:0] result,
  output logic         eq,
  output logic         lt
);
  import fpga_runner_pkg::*;

  always_comb begin
    a_val  = a_imm ? a_field : a_mem;
    b_val  = b_imm ? b_field : b_mem;
    eq     = (a_val == b_val);
    lt     = (a_val < b_val);
    result = a_val;
    case (op)
      OP_ADD:  result = a_val + b_val;
      OP_SUB:  result = a_val - b_val;
      default: result = a_val;
    endcase
  end

endmodule

// File: rtl/fpga_program_runner.sv
// Loadable-program test harness: clears local memory, executes one instruction per clock,
// then compares the captured output stream against a loadable expected table.
module fpga_program_runner
  import fpga_runner_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = 12,
  parameter int unsigned NLocal             = 16,
  parameter int unsigned NOut               = 8,
  parameter int unsigned NProgram           = 32,
  parameter int unsigned MaxSteps           = 1024,
  localparam int unsigned LAW = $clog2(NLocal),
  localparam int unsigned OAW = $clog2(NOut),
  localparam int unsigned PAW = $clog2(NProgram),
  localparam int unsigned IW  = instr_width(MemoryElementWidth)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_valid,
  input  logic [PAW-1:0]                load_addr,
  input  logic [IW-1:0]                 load_instr,
  input  logic                          expect_valid,
  input  logic [OAW-1:0]                expect_addr,
  input  logic [MemoryElementWidth-1:0] expect_value,
  input  logic [OAW:0]                  expect_count,
  input  logic                          start,
  output logic                          busy,
  output logic                          finished,
  output logic                          success,
  output logic                          timeout,
  output logic [31:0]                   steps,
  output logic                          out_valid,
  output logic [MemoryElementWidth-1:0] out_value
);

  localparam int unsigned W     = MemoryElementWidth;
  localparam int unsigned OCW   = $clog2(NOut + 2);
  localparam int unsigned ECW   = OAW + 1;
  localparam int unsigned TAW   = (PAW > LAW) ? PAW : LAW;
  localparam int unsigned OFF_B  = off_b(W);
  localparam int unsigned OFF_BI = off_b_imm(W);
  localparam int unsigned OFF_A  = off_a(W);
  localparam int unsigned OFF_AI = off_a_imm(W);
  localparam int unsigned OFF_T  = off_target(W);
  localparam int unsigned OFF_OP = off_opcode(W);

  localparam logic [PAW:0]   PROG_END  = (PAW + 1)'(NProgram);
  localparam logic [31:0]    MAX_STEPS = 32'(MaxSteps);
  localparam logic [LAW-1:0] CLR_LAST  = LAW'(NLocal - 1);
  localparam logic [OAW-1:0] OUT_LAST  = OAW'(NOut - 1);
  localparam logic [OCW-1:0] OUT_SAT   = OCW'(NOut + 1);
  localparam logic [ECW-1:0] EXP_DEPTH = ECW'(NOut);

  logic [IW-1:0] prog_mem  [NProgram];
  logic [W-1:0]  exp_mem   [NOut];
  logic [W-1:0]  out_mem   [NOut];
  logic [W-1:0]  local_mem [NLocal];

  state_e         state;
  logic [PAW-1:0] ip;
  logic [LAW-1:0] clr_idx;
  logic [OAW-1:0] out_pos;
  logic [OCW-1:0] out_cnt;
  logic [ECW-1:0] exp_cnt;
  logic [ECW-1:0] chk_idx;
  logic           mismatch;
  logic           illegal;

  logic [IW-1:0]  instr;
  logic [3:0]     op;
  logic [W-1:0]   tgt, a_field, b_field;
  logic           a_imm, b_imm;
  logic [W-1:0]   a_mem, b_mem, a_val, b_val, alu_res;
  logic           eq, lt;
  logic           unused_tgt_bits;

  logic [PAW:0]   ip_seq, ip_next;
  logic           jump, op_illegal, halt, wr_local;
  logic [31:0]    steps_inc;
  logic [OAW-1:0] out_pos_inc;
  logic           chk_bad, chk_last, cnt_ok;

  // Instruction fetch and field decode
  assign instr   = prog_mem[ip];
  assign op      = instr[OFF_OP +: OPCODE_W];
  assign tgt     = instr[OFF_T +: W];
  assign a_imm   = instr[OFF_AI];
  assign a_field = instr[OFF_A +: W];
  assign b_imm   = instr[OFF_BI];
  assign b_field = instr[OFF_B +: W];
  assign a_mem   = local_mem[a_field[LAW-1:0]];
  assign b_mem   = local_mem[b_field[LAW-1:0]];
  assign unused_tgt_bits = ^tgt[W-1:TAW];

  fpga_runner_alu #(.W(W)) u_alu (
    .op      (op),
    .a_imm   (a_imm),
    .a_field (a_field),
    .a_mem   (a_mem),
    .b_imm   (b_imm),
    .b_field (b_field),
    .b_mem   (b_mem),
    .a_val   (a_val),
    .b_val   (b_val),
    .result  (alu_res),
    .eq      (eq),
    .lt      (lt)
  );

  // Sequencing, halt detection and check-phase compare
  always_comb begin
    ip_seq      = {1'b0, ip} + (PAW + 1)'(1);
    jump        = ((op == OP_JEQ) && eq) || ((op == OP_JLT) && lt);
    ip_next     = jump ? {1'b0, tgt[PAW-1:0]} : ip_seq;
    op_illegal  = op[3];
    halt        = op_illegal || (op == OP_HALT) || (ip_next >= PROG_END);
    steps_inc   = steps + 32'd1;
    out_pos_inc = (out_pos == OUT_LAST) ? '0 : out_pos + OAW'(1);
    wr_local    = (state == ST_EXEC) && ((op == OP_ADD) || (op == OP_SUB) || (op == OP_MOV));
    // Entries past the output depth can never match.
    chk_bad     = (exp_cnt != '0) &&
                  ((chk_idx >= EXP_DEPTH) || (out_mem[chk_idx[OAW-1:0]] != exp_mem[chk_idx[OAW-1:0]]));
    chk_last    = (exp_cnt <= chk_idx + ECW'(1));
    cnt_ok      = (32'(out_cnt) == 32'(exp_cnt));
  end

  // Host-side loads are locked out while a run is in progress
  always_ff @(posedge clock) begin
    if (load_valid && !busy) prog_mem[load_addr] <= load_instr;
    if (expect_valid && !busy) exp_mem[expect_addr] <= expect_value;
  end

  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) local_mem[clr_idx] <= '0;
    else if (wr_local) local_mem[tgt[LAW-1:0]] <= alu_res;
  end

  always_ff @(posedge clock) begin
    if ((state == ST_EXEC) && (op == OP_OUT)) out_mem[out_pos] <= a_val;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      ip        <= '0;
      steps     <= '0;
      clr_idx   <= '0;
      out_pos   <= '0;
      out_cnt   <= '0;
      exp_cnt   <= '0;
      chk_idx   <= '0;
      mismatch  <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
      finished  <= 1'b0;
      success   <= 1'b0;
      timeout   <= 1'b0;
      out_valid <= 1'b0;
      out_value <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_CLEAR;
            ip       <= '0;
            steps    <= '0;
            clr_idx  <= '0;
            out_pos  <= '0;
            out_cnt  <= '0;
            exp_cnt  <= expect_count;
            chk_idx  <= '0;
            mismatch <= 1'b0;
            illegal  <= 1'b0;
            busy     <= 1'b1;
            finished <= 1'b0;
            success  <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          clr_idx <= clr_idx + LAW'(1);
          if (clr_idx == CLR_LAST) state <= ST_EXEC;
        end
        ST_EXEC: begin
          steps <= steps_inc;
          ip    <= ip_next[PAW-1:0];
          if (op == OP_OUT) begin
            out_valid <= 1'b1;
            out_value <= a_val;
            out_pos   <= out_pos_inc;
            if (out_cnt != OUT_SAT) out_cnt <= out_cnt + OCW'(1);
          end
          if (op_illegal) illegal <= 1'b1;
          // Step limit wins over any halt on the same instruction
          if (steps_inc == MAX_STEPS) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
            timeout  <= 1'b1;
            success  <= 1'b0;
          end else if (halt) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          chk_idx <= chk_idx + ECW'(1);
          if (chk_bad) mismatch <= 1'b1;
          if (chk_last) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
            success  <= !(mismatch || chk_bad) && cnt_ok && !illegal;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
